// File: rtl/ninjakun_psg_bus_arbiter_pkg.sv
// Shared definitions for the two-requester PSG bus arbiter: FSM states,
// PSG address field positions and the value returned by address-latch reads.
package ninjakun_psg_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REPLAY,
    ST_REPLAY_GAP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam int ADR_CHIP = 1;
  localparam int ADR_DATA = 0;

  localparam logic [7:0] READ_IDLE_VAL = 8'hFF;

  function automatic logic is_cs_state(input state_t s);
    return (s == ST_REPLAY) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/ninjakun_psg_bus_arbiter_rr2.sv
// Two-way round-robin grant: a lone request wins outright, and a tie goes to
// whichever requester was not served last.
module ninjakun_psg_bus_arbiter_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic [1:0] gnt
);

  // Resets to "requester 1 was last" so the first tie favours requester 0.
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ninjakun_psg_bus_arbiter.sv
// Serialises main/sub CPU accesses onto the shared PSG bus. Each requester keeps a
// private view of every chip's address latch, and that view is replayed when needed.
module ninjakun_psg_bus_arbiter
  import ninjakun_psg_bus_arbiter_pkg::*;
#(
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic       MCLK,
  input  logic       RESET_L,
  input  logic       R0_REQ,
  input  logic       R0_WR,
  input  logic [1:0] R0_ADR,
  input  logic [7:0] R0_DI,
  output logic [7:0] R0_DO,
  output logic       R0_ACK,
  input  logic       R1_REQ,
  input  logic       R1_WR,
  input  logic [1:0] R1_ADR,
  input  logic [7:0] R1_DI,
  output logic [7:0] R1_DO,
  output logic       R1_ACK,
  output logic       PSG_CS,
  output logic       PSG_WR,
  output logic [1:0] PSG_ADR,
  output logic [7:0] PSG_ID,
  input  logic [7:0] PSG_OD
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
  localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state, next_state;
  logic [3:0] cnt;
  logic       cnt_zero;

  logic       gidx;
  logic       lwr;
  logic [1:0] ladr;
  logic [7:0] ldi;

  logic [7:0] shadow [2][2];
  logic [7:0] cur [2];

  logic [1:0] gnt;
  logic       new_idx, new_valid;
  logic       sel_wr;
  logic [1:0] sel_adr;
  logic [7:0] sel_di;

  logic       eff_idx, eff_wr, eff_chip;
  logic [1:0] eff_adr;
  logic [7:0] eff_di;
  logic       needs_replay;

  logic       cs_d, wr_d;
  logic [1:0] adr_d;
  logic [7:0] id_d;
  logic [1:0] ack_d;

  ninjakun_psg_bus_arbiter_rr2 u_rr (
    .clk    (MCLK),
    .rst_n  (RESET_L),
    .req    ({R1_REQ, R0_REQ}),
    .update (state == ST_DONE),
    .upd_idx(gidx),
    .gnt    (gnt)
  );

  assign new_idx   = gnt[1];
  assign new_valid = |gnt;
  assign sel_wr    = new_idx ? R1_WR  : R0_WR;
  assign sel_adr   = new_idx ? R1_ADR : R0_ADR;
  assign sel_di    = new_idx ? R1_DI  : R0_DI;

  // In IDLE the request being granted this edge is still on the inputs.
  assign eff_idx  = (state == ST_IDLE) ? new_idx : gidx;
  assign eff_wr   = (state == ST_IDLE) ? sel_wr  : lwr;
  assign eff_adr  = (state == ST_IDLE) ? sel_adr : ladr;
  assign eff_di   = (state == ST_IDLE) ? sel_di  : ldi;
  assign eff_chip = eff_adr[ADR_CHIP];

  assign needs_replay = (cur[eff_chip] != shadow[eff_idx][eff_chip]);
  assign cnt_zero     = (cnt == 4'd0);

  always_ff @(posedge MCLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (new_valid) begin
          if (!sel_adr[ADR_DATA]) begin
            next_state = sel_wr ? ST_ACCESS : ST_DONE;
          end else begin
            next_state = needs_replay ? ST_REPLAY : ST_ACCESS;
          end
        end
      end
      ST_REPLAY: begin
        if (cnt_zero) begin
          next_state = (GAP == 0) ? ST_ACCESS : ST_REPLAY_GAP;
        end
      end
      ST_REPLAY_GAP: begin
        if (cnt_zero) begin
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so the CS window opens on the grant edge.
  always_comb begin
    cs_d  = is_cs_state(next_state);
    wr_d  = 1'b0;
    adr_d = 2'b00;
    id_d  = 8'h00;
    ack_d = 2'b00;
    case (next_state)
      ST_REPLAY: begin
        wr_d  = 1'b1;
        adr_d = {eff_chip, 1'b0};
        id_d  = shadow[eff_idx][eff_chip];
      end
      ST_ACCESS: begin
        wr_d  = eff_wr;
        adr_d = eff_adr;
        id_d  = eff_di;
      end
      ST_DONE:  ack_d[eff_idx] = 1'b1;
      default:  ack_d = 2'b00;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_L) begin
    if (!RESET_L) begin
      PSG_CS  <= 1'b0;
      PSG_WR  <= 1'b0;
      PSG_ADR <= 2'b00;
      PSG_ID  <= 8'h00;
      R0_ACK  <= 1'b0;
      R1_ACK  <= 1'b0;
    end else begin
      PSG_CS  <= cs_d;
      PSG_WR  <= wr_d;
      PSG_ADR <= adr_d;
      PSG_ID  <= id_d;
      R0_ACK  <= ack_d[0];
      R1_ACK  <= ack_d[1];
    end
  end

  always_ff @(posedge MCLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt   <= 4'd0;
      gidx  <= 1'b0;
      lwr   <= 1'b0;
      ladr  <= 2'b00;
      ldi   <= 8'h00;
      cur   <= '{default: 8'h00};
      shadow <= '{default: '{default: 8'h00}};
      R0_DO <= 8'h00;
      R1_DO <= 8'h00;
    end else begin
      if (state == ST_IDLE && new_valid) begin
        gidx <= new_idx;
        lwr  <= sel_wr;
        ladr <= sel_adr;
        ldi  <= sel_di;
        if (!sel_adr[ADR_DATA] && sel_wr) begin
          shadow[new_idx][sel_adr[ADR_CHIP]] <= sel_di;
          cur[sel_adr[ADR_CHIP]]             <= sel_di;
        end
      end

      if (next_state == ST_REPLAY && state != ST_REPLAY) begin
        cur[eff_chip] <= shadow[eff_idx][eff_chip];
      end

      // Latch reads never touch the PSG, so they answer with a fixed value.
      if (state == ST_IDLE && new_valid && !sel_adr[ADR_DATA] && !sel_wr) begin
        if (new_idx) R1_DO <= READ_IDLE_VAL;
        else         R0_DO <= READ_IDLE_VAL;
      end else if (state == ST_ACCESS && cnt_zero && !lwr) begin
        if (gidx) R1_DO <= PSG_OD;
        else      R0_DO <= PSG_OD;
      end

      if (next_state != state) begin
        case (next_state)
          ST_REPLAY, ST_ACCESS: cnt <= HOLD_LOAD;
          ST_REPLAY_GAP:        cnt <= GAP_LOAD;
          default:              cnt <= 4'd0;
        endcase
      end else if (!cnt_zero) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ninjakun_psg_bus_arbiter.sv
// Directed bench for the PSG bus arbiter: a default build (HOLD=2, GAP=1) and a
// HOLD=1, GAP=0 build side by side, with hand-computed latencies and bus contents.
module tb_ninjakun_psg_bus_arbiter;

  typedef struct {
    int         lat;
    int         cs_cyc;
    int         windows;
    logic [1:0] first_adr;
    logic [7:0] first_id;
    logic       first_wr;
    logic [1:0] last_adr;
    logic       last_wr;
    logic [7:0] rd;
  } res_t;

  logic       clock = 1'b0;
  logic       reset_l;
  logic       req [2][2];
  logic       wr [2][2];
  logic [1:0] adr [2][2];
  logic [7:0] di [2][2];
  logic [7:0] rdo [2][2];
  logic       ack [2][2];
  logic       cs [2];
  logic       pwr [2];
  logic [1:0] padr [2];
  logic [7:0] pid [2];
  logic [7:0] od;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ninjakun_psg_bus_arbiter #(.HOLD(2), .GAP(1)) dut (
    .MCLK(clock), .RESET_L(reset_l),
    .R0_REQ(req[0][0]), .R0_WR(wr[0][0]), .R0_ADR(adr[0][0]), .R0_DI(di[0][0]),
    .R0_DO(rdo[0][0]), .R0_ACK(ack[0][0]),
    .R1_REQ(req[0][1]), .R1_WR(wr[0][1]), .R1_ADR(adr[0][1]), .R1_DI(di[0][1]),
    .R1_DO(rdo[0][1]), .R1_ACK(ack[0][1]),
    .PSG_CS(cs[0]), .PSG_WR(pwr[0]), .PSG_ADR(padr[0]), .PSG_ID(pid[0]), .PSG_OD(od)
  );

  ninjakun_psg_bus_arbiter #(.HOLD(1), .GAP(0)) dut_fast (
    .MCLK(clock), .RESET_L(reset_l),
    .R0_REQ(req[1][0]), .R0_WR(wr[1][0]), .R0_ADR(adr[1][0]), .R0_DI(di[1][0]),
    .R0_DO(rdo[1][0]), .R0_ACK(ack[1][0]),
    .R1_REQ(req[1][1]), .R1_WR(wr[1][1]), .R1_ADR(adr[1][1]), .R1_DI(di[1][1]),
    .R1_DO(rdo[1][1]), .R1_ACK(ack[1][1]),
    .PSG_CS(cs[1]), .PSG_WR(pwr[1]), .PSG_ADR(padr[1]), .PSG_ID(pid[1]), .PSG_OD(od)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one request, watches the bus until ACK (bounded), then releases it.
  task automatic apply_stimulus(input string tag, input int d, input int r, input logic w,
                                input logic [1:0] a, input logic [7:0] v,
                                input bit drop_early, output res_t res);
    logic prev_cs;
    prev_cs = 1'b0;
    res = '{lat: 0, cs_cyc: 0, windows: 0, first_adr: 2'b00, first_id: 8'h00,
            first_wr: 1'b0, last_adr: 2'b00, last_wr: 1'b0, rd: 8'h00};
    wr[d][r]  = w;
    adr[d][r] = a;
    di[d][r]  = v;
    req[d][r] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (drop_early && n == 1) req[d][r] = 1'b0;
      if (cs[d]) begin
        res.cs_cyc++;
        if (!prev_cs) begin
          res.windows++;
          if (res.windows == 1) begin
            res.first_adr = padr[d];
            res.first_id  = pid[d];
            res.first_wr  = pwr[d];
          end
        end
        res.last_adr = padr[d];
        res.last_wr  = pwr[d];
      end
      prev_cs = cs[d];
      if (ack[d][r]) begin
        res.lat = n;
        res.rd  = rdo[d][r];
        break;
      end
    end
    req[d][r] = 1'b0;
    check_output({tag, "_ack_seen"}, 32'(res.lat != 0), 32'd1);
    step();
    check_output({tag, "_ack_pulse"}, 32'(ack[d][r]), 32'd0);
  endtask

  initial begin
    res_t res;
    int   t0a, t0b, t1, n0;

    reset_l = 1'b0;
    od = 8'h00;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0;
        wr[d][r]  = 1'b0;
        adr[d][r] = 2'b00;
        di[d][r]  = 8'h00;
      end
    end
    repeat (3) step();
    check_output("rst_cs", 32'(cs[0]), 32'd0);
    check_output("rst_ack0", 32'(ack[0][0]), 32'd0);
    check_output("rst_ack1", 32'(ack[0][1]), 32'd0);
    check_output("rst_do0", 32'(rdo[0][0]), 32'd0);
    check_output("rst_id", 32'(pid[0]), 32'd0);
    reset_l = 1'b1;
    step();

    // Address write then data write, same owner: no replay
    apply_stimulus("aw7", 0, 0, 1'b1, 2'b00, 8'h07, 1'b0, res);
    check_output("aw7_lat", 32'(res.lat), 32'd3);
    check_output("aw7_cs", 32'(res.cs_cyc), 32'd2);
    check_output("aw7_adr", 32'(res.first_adr), 32'h0);
    check_output("aw7_id", 32'(res.first_id), 32'h07);
    apply_stimulus("dw38", 0, 0, 1'b1, 2'b01, 8'h38, 1'b0, res);
    check_output("dw38_lat", 32'(res.lat), 32'd3);
    check_output("dw38_win", 32'(res.windows), 32'd1);
    check_output("dw38_adr", 32'(res.first_adr), 32'h1);
    check_output("dw38_id", 32'(res.first_id), 32'h38);

    // R1 re-points PSG0, so R0's data read must replay register 8 first
    apply_stimulus("r0aw8", 0, 0, 1'b1, 2'b00, 8'h08, 1'b0, res);
    apply_stimulus("r1aw2", 0, 1, 1'b1, 2'b00, 8'h02, 1'b0, res);
    check_output("r1aw2_lat", 32'(res.lat), 32'd3);
    od = 8'hA5;
    apply_stimulus("rpl0", 0, 0, 1'b0, 2'b01, 8'h00, 1'b0, res);
    check_output("rpl0_lat", 32'(res.lat), 32'd6);
    check_output("rpl0_cs", 32'(res.cs_cyc), 32'd4);
    check_output("rpl0_win", 32'(res.windows), 32'd2);
    check_output("rpl0_fadr", 32'(res.first_adr), 32'h0);
    check_output("rpl0_fid", 32'(res.first_id), 32'h08);
    check_output("rpl0_fwr", 32'(res.first_wr), 32'd1);
    check_output("rpl0_ladr", 32'(res.last_adr), 32'h1);
    check_output("rpl0_lwr", 32'(res.last_wr), 32'd0);
    check_output("rpl0_do", 32'(res.rd), 32'hA5);
    od = 8'h3C;
    apply_stimulus("rpl1", 0, 1, 1'b0, 2'b01, 8'h00, 1'b0, res);
    check_output("rpl1_lat", 32'(res.lat), 32'd6);
    check_output("rpl1_fid", 32'(res.first_id), 32'h02);
    check_output("rpl1_do", 32'(res.rd), 32'h3C);

    // Equal latch values written by different owners need no replay
    apply_stimulus("r1aw5", 0, 1, 1'b1, 2'b10, 8'h05, 1'b0, res);
    apply_stimulus("r0aw5", 0, 0, 1'b1, 2'b10, 8'h05, 1'b0, res);
    apply_stimulus("eqdw", 0, 1, 1'b1, 2'b11, 8'h77, 1'b0, res);
    check_output("eqdw_lat", 32'(res.lat), 32'd3);
    check_output("eqdw_adr", 32'(res.first_adr), 32'h3);
    check_output("eqdw_id", 32'(res.first_id), 32'h77);

    // Address-latch read: no bus cycle, fixed data, ACK next cycle
    apply_stimulus("ard", 0, 1, 1'b0, 2'b10, 8'h00, 1'b0, res);
    check_output("ard_lat", 32'(res.lat), 32'd1);
    check_output("ard_cs", 32'(res.cs_cyc), 32'd0);
    check_output("ard_do", 32'(res.rd), 32'hFF);

    // Request withdrawn after the grant still completes
    apply_stimulus("drop", 0, 1, 1'b1, 2'b01, 8'h11, 1'b1, res);
    check_output("drop_lat", 32'(res.lat), 32'd3);

    // Async reset while the replay cycle is on the bus
    wr[0][0] = 1'b1; adr[0][0] = 2'b01; di[0][0] = 8'h44; req[0][0] = 1'b1;
    step();
    check_output("mid_cs", 32'(cs[0]), 32'd1);
    check_output("mid_id", 32'(pid[0]), 32'h08);
    reset_l = 1'b0;
    #1;
    check_output("arst_cs", 32'(cs[0]), 32'd0);
    check_output("arst_id", 32'(pid[0]), 32'd0);
    check_output("arst_ack", 32'(ack[0][0]), 32'd0);
    req[0][0] = 1'b0;
    step();
    step();
    reset_l = 1'b1;
    check_output("arst_do0", 32'(rdo[0][0]), 32'd0);
    check_output("arst_do1", 32'(rdo[0][1]), 32'd0);

    // Simultaneous requests from reset; R0 comes straight back while R1 waits
    t0a = 0; t0b = 0; t1 = 0; n0 = 0;
    wr[0][0] = 1'b1; adr[0][0] = 2'b10; di[0][0] = 8'h03;
    wr[0][1] = 1'b1; adr[0][1] = 2'b10; di[0][1] = 8'h04;
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ack[0][0]) begin
        n0++;
        if (n0 == 1) t0a = n;
        else begin
          t0b = n;
          req[0][0] = 1'b0;
        end
      end
      if (ack[0][1]) begin
        t1 = n;
        req[0][1] = 1'b0;
      end
      if (n0 == 2 && t1 != 0) break;
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    step();
    check_output("rr_r0_first", 32'(t0a), 32'd3);
    check_output("rr_r1_next", 32'(t1), 32'd7);
    check_output("rr_r0_again", 32'(t0b), 32'd11);

    // Post-reset shadows are zero: data access to register 0 needs no replay
    apply_stimulus("pr", 0, 0, 1'b1, 2'b01, 8'h44, 1'b0, res);
    check_output("pr_lat", 32'(res.lat), 32'd3);
    check_output("pr_win", 32'(res.windows), 32'd1);
    check_output("pr_id", 32'(res.first_id), 32'h44);

    // HOLD=1, GAP=0: replay and data windows run back-to-back
    apply_stimulus("f_aw9", 1, 0, 1'b1, 2'b00, 8'h09, 1'b0, res);
    check_output("f_aw9_lat", 32'(res.lat), 32'd2);
    apply_stimulus("f_aw1", 1, 1, 1'b1, 2'b00, 8'h01, 1'b0, res);
    apply_stimulus("f_rpl", 1, 0, 1'b1, 2'b01, 8'h5A, 1'b0, res);
    check_output("f_rpl_lat", 32'(res.lat), 32'd3);
    check_output("f_rpl_cs", 32'(res.cs_cyc), 32'd2);
    check_output("f_rpl_win", 32'(res.windows), 32'd1);
    check_output("f_rpl_fadr", 32'(res.first_adr), 32'h0);
    check_output("f_rpl_fid", 32'(res.first_id), 32'h09);
    check_output("f_rpl_ladr", 32'(res.last_adr), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
